// File: rtl/aibcr3_buf_seq_pkg.sv
// Shared types and reset values for the aibcr3_buf_seq sequencer.
package aibcr3_buf_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF, ST_PADREL, ST_RXEN, ST_TXEN, ST_RUN, ST_DOWN
  } state_e;

  typedef struct packed {
    logic       txen;
    logic [2:0] rxen;
    logic [1:0] pdrv;
    logic [1:0] ndrv;
    logic       ddren;
    logic       weakpu;
  } cfg_t;

  typedef struct packed {
    logic       itxen;
    logic [2:0] irxen;
    logic [1:0] ipdrv;
    logic [1:0] indrv;
    logic       iddren;
    logic       ipadrstb;
    logic       irstb;
    logic       weakpd;
    logic       weakpu;
    logic       ready;
  } out_t;

  localparam logic       ITXEN_RST    = 1'b0;
  localparam logic [1:0] DRV_RST      = 2'd0;
  localparam logic       IDDREN_RST   = 1'b0;
  localparam logic       IPADRSTB_RST = 1'b0;
  localparam logic       IRSTB_RST    = 1'b0;
  localparam logic       WEAKPD_RST   = 1'b1;
  localparam logic       WEAKPU_RST   = 1'b0;
  localparam logic       READY_RST    = 1'b0;
  localparam cfg_t       CFG_RST      = '0;

  // irxen's idle code is a top-level parameter, so it is passed in
  function automatic out_t out_rst(input logic [2:0] rx_off);
    out_t o;
    o.itxen    = ITXEN_RST;
    o.irxen    = rx_off;
    o.ipdrv    = DRV_RST;
    o.indrv    = DRV_RST;
    o.iddren   = IDDREN_RST;
    o.ipadrstb = IPADRSTB_RST;
    o.irstb    = IRSTB_RST;
    o.weakpd   = WEAKPD_RST;
    o.weakpu   = WEAKPU_RST;
    o.ready    = READY_RST;
    return o;
  endfunction

  function automatic logic [1:0] sat2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/aibcr3_sync2.sv
// Two-flop synchronizer; reset forces the output high (supply "not good").
module aibcr3_sync2 (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/aibcr3_buf_seq.sv
// AIB IO buffer power-up / reconfig / shutdown sequencer.
// Optional drive ramp in TXEN: define AIBCR3_BUF_SEQ_DRV_RAMP_EN.
module aibcr3_buf_seq
  import aibcr3_buf_seq_pkg::*;
#(
  parameter int         WAIT_CYC = 16,
  parameter logic [2:0] RX_OFF   = 3'b000
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       por_aib_vcc1,
  input  logic       por_aib_vcchssi,
  input  logic       en,
  input  logic       cfg_req,
  output logic       cfg_ack,
  input  logic       cfg_txen,
  input  logic [2:0] cfg_rxen,
  input  logic [1:0] cfg_pdrv,
  input  logic [1:0] cfg_ndrv,
  input  logic       cfg_ddren,
  input  logic       cfg_weakpu,
  output logic       itxen,
  output logic [2:0] irxen,
  output logic [1:0] ipdrv,
  output logic [1:0] indrv,
  output logic       iddren,
  output logic       ipadrstb,
  output logic       irstb,
  output logic       test_weakpd,
  output logic       test_weakpu,
  output logic       ready
);
  localparam int            CW    = $clog2(WAIT_CYC + 1);
  localparam logic [CW-1:0] DWELL = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic   vcc1_bad, hssi_bad, por_ok;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] step_q, step_d;
  logic   ack_q, ack_d;
  cfg_t   shd_q, shd_d;
  out_t   out_q, out_d;
  logic   dwell_done, abort;

  aibcr3_sync2 u_sync_vcc1 (.clk(clk), .rstb(rstb), .d(por_aib_vcc1),    .q(vcc1_bad));
  aibcr3_sync2 u_sync_hssi (.clk(clk), .rstb(rstb), .d(por_aib_vcchssi), .q(hssi_bad));
  assign por_ok = !vcc1_bad && !hssi_bad;

`ifdef AIBCR3_BUF_SEQ_DRV_RAMP_EN
  logic [1:0] max_tgt;
  always_comb begin
    max_tgt = (shd_q.pdrv > shd_q.ndrv) ? shd_q.pdrv : shd_q.ndrv;
    if (max_tgt == 2'd0) max_tgt = 2'd1;
  end
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      step_q  <= '0;
      ack_q   <= 1'b0;
      shd_q   <= CFG_RST;
      out_q   <= out_rst(RX_OFF);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      ack_q   <= ack_d;
      shd_q   <= shd_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    ack_d      = 1'b0;
    dwell_done = (cnt_q == '0);
    abort      = !en || cfg_req;
    if (!por_ok) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      step_d  = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          // ack_q guard keeps one pulse while the requester reacts to ack
          if (cfg_req) ack_d = !ack_q;
          else if (en) begin state_d = ST_PADREL; cnt_d = DWELL; end
        end
        ST_PADREL: begin
          if (abort) begin state_d = ST_DOWN; cnt_d = DWELL; step_d = '0; end
          else if (!dwell_done) cnt_d = cnt_q - ONE;
          else begin state_d = ST_RXEN; cnt_d = DWELL; end
        end
        ST_RXEN: begin
          if (abort) begin state_d = ST_DOWN; cnt_d = DWELL; step_d = '0; end
          else if (!dwell_done) cnt_d = cnt_q - ONE;
          else begin state_d = ST_TXEN; cnt_d = DWELL; step_d = 2'd1; end
        end
        ST_TXEN: begin
          if (abort) begin state_d = ST_DOWN; cnt_d = DWELL; step_d = '0; end
          else if (!dwell_done) cnt_d = cnt_q - ONE;
`ifdef AIBCR3_BUF_SEQ_DRV_RAMP_EN
          else if (step_q < max_tgt) begin step_d = step_q + 2'd1; cnt_d = DWELL; end
`endif
          else state_d = ST_RUN;
        end
        ST_RUN: begin
          if (abort) begin state_d = ST_DOWN; cnt_d = DWELL; step_d = '0; end
        end
        ST_DOWN: begin
          // step 0: rx still on; step 1: rx off, pad reset pending
          if (!dwell_done) cnt_d = cnt_q - ONE;
          else if (step_q == 2'd0) begin step_d = 2'd1; cnt_d = DWELL; end
          else begin state_d = ST_OFF; step_d = '0; end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_comb shd_d = ack_d ? cfg_t'({cfg_txen, cfg_rxen, cfg_pdrv, cfg_ndrv, cfg_ddren, cfg_weakpu})
                            : shd_q;

  // Outputs decode the next state so they land on the first cycle of each state
  always_comb begin
    out_d = out_rst(RX_OFF);
    unique case (state_d)
      ST_PADREL: out_d.ipadrstb = 1'b1;
      ST_RXEN: begin
        out_d.ipadrstb = 1'b1;
        out_d.irxen    = shd_q.rxen;
      end
      ST_TXEN, ST_RUN: begin
        out_d.ipadrstb = 1'b1;
        out_d.irxen    = shd_q.rxen;
        out_d.itxen    = shd_q.txen;
        out_d.iddren   = shd_q.ddren;
`ifdef AIBCR3_BUF_SEQ_DRV_RAMP_EN
        out_d.ipdrv    = (state_d == ST_RUN) ? shd_q.pdrv : sat2(step_d, shd_q.pdrv);
        out_d.indrv    = (state_d == ST_RUN) ? shd_q.ndrv : sat2(step_d, shd_q.ndrv);
`else
        out_d.ipdrv    = shd_q.pdrv;
        out_d.indrv    = shd_q.ndrv;
`endif
        if (state_d == ST_RUN) begin
          out_d.irstb  = 1'b1;
          out_d.ready  = 1'b1;
          out_d.weakpd = shd_q.txen ? 1'b0 : !shd_q.weakpu;
          out_d.weakpu = shd_q.txen ? 1'b0 : shd_q.weakpu;
        end
      end
      ST_DOWN: begin
        out_d.ipadrstb = 1'b1;
        out_d.irxen    = (step_d == 2'd0) ? out_q.irxen : RX_OFF;
      end
      default: ;
    endcase
  end

  assign cfg_ack     = ack_q;
  assign itxen       = out_q.itxen;
  assign irxen       = out_q.irxen;
  assign ipdrv       = out_q.ipdrv;
  assign indrv       = out_q.indrv;
  assign iddren      = out_q.iddren;
  assign ipadrstb    = out_q.ipadrstb;
  assign irstb       = out_q.irstb;
  assign test_weakpd = out_q.weakpd;
  assign test_weakpu = out_q.weakpu;
  assign ready       = out_q.ready;
endmodule
